// File: rtl/skin_centroid.sv
// skin_centroid: accumulates skin-pixel count and coordinate sums over each
// frame of a binary mask stream, then divides at frame end (restoring,
// one quotient bit per enabled cycle) to present the floor centroid.
module skin_centroid #(
    parameter int H_BITS     = 11,
    parameter int V_BITS     = 11,
    parameter int MIN_PIXELS = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic [7:0]               skin,
    input  logic                     de_in,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    output logic [H_BITS-1:0]        x_c,
    output logic [V_BITS-1:0]        y_c,
    output logic [H_BITS+V_BITS-1:0] pix_count,
    output logic                     detected,
    output logic                     valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int CW  = H_BITS + V_BITS;            // pixel count width
    localparam int SXW = 2 * H_BITS + V_BITS;        // sum of x width
    localparam int SYW = H_BITS + 2 * V_BITS;        // sum of y width
    localparam int N   = (H_BITS > V_BITS) ? H_BITS : V_BITS;
    localparam int DW  = CW + N + 1;                 // divider datapath width
    localparam int IW  = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);
    localparam logic [N-1:0]  Q_HMAX  = N'((64'd1 << H_BITS) - 64'd1);
    localparam logic [N-1:0]  Q_VMAX  = N'((64'd1 << V_BITS) - 64'd1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    // Horizontal sync carries no information for counting; it is accepted
    // only so the port list stays aligned with the upstream stage.
    logic unused_hsync;
    assign unused_hsync = hsync_in;

    logic              de_d, vs_d;
    logic [H_BITS-1:0] x;
    logic [V_BITS-1:0] y;
    logic [CW-1:0]     count;
    logic [SXW-1:0]    sum_x;
    logic [SYW-1:0]    sum_y;

    logic              frame_end, line_end, pix;

    assign frame_end = vsync_in & ~vs_d;
    assign line_end  = ~de_in & de_d;
    assign pix       = de_in & (skin != 8'd0);

    state_t            state;
    logic [IW-1:0]     cnt;
    logic [DW-1:0]     rem_x, rem_y, dsh;
    logic [N-1:0]      q_x, q_y;
    logic [CW-1:0]     snap_count;
    logic              sat_x, sat_y, div_en;

    logic              ge_x, ge_y, sat_x_load, sat_y_load, start_div;

    assign ge_x       = rem_x >= dsh;
    assign ge_y       = rem_y >= dsh;
    // A quotient that needs more than N bits can only come from an
    // inconsistent count; flag it at load so the result saturates.
    assign sat_x_load = DW'(sum_x) >= (DW'(count) << N);
    assign sat_y_load = DW'(sum_y) >= (DW'(count) << N);
    assign start_div  = (count >= MIN_CNT) && (count != '0);

    // Edge detectors, pixel coordinates and per-frame accumulators.
    // NOTE: every sequential assignment is non-blocking so all registers see
    // the pre-edge values of each other, exactly like the hardware does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_d  <= 1'b0;
            vs_d  <= 1'b0;
            x     <= '0;
            y     <= '0;
            count <= '0;
            sum_x <= '0;
            sum_y <= '0;
        end else if (ce) begin
            de_d <= de_in;
            vs_d <= vsync_in;

            if (line_end)
                x <= '0;
            else if (de_in && x != '1)
                x <= x + H_BITS'(1);

            if (frame_end)
                y <= '0;
            else if (line_end && y != '1)
                y <= y + V_BITS'(1);

            // A pixel arriving in the frame-end cycle seeds the next frame.
            if (frame_end) begin
                count <= pix ? CW'(1)   : '0;
                sum_x <= pix ? SXW'(x)  : '0;
                sum_y <= pix ? SYW'(y)  : '0;
            end else if (pix) begin
                count <= count + CW'(1);
                sum_x <= sum_x + SXW'(x);
                sum_y <= sum_y + SYW'(y);
            end
        end
    end

    // Control FSM with the two parallel restoring dividers and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rem_x      <= '0;
            rem_y      <= '0;
            dsh        <= '0;
            q_x        <= '0;
            q_y        <= '0;
            snap_count <= '0;
            sat_x      <= 1'b0;
            sat_y      <= 1'b0;
            div_en     <= 1'b0;
            x_c        <= '0;
            y_c        <= '0;
            pix_count  <= '0;
            detected   <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else if (!ce) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid   <= 1'b0;
            overrun <= frame_end && (state != IDLE);

            case (state)
                IDLE: begin
                    if (frame_end) begin
                        rem_x      <= DW'(sum_x);
                        rem_y      <= DW'(sum_y);
                        dsh        <= DW'(count) << (N - 1);
                        snap_count <= count;
                        sat_x      <= sat_x_load;
                        sat_y      <= sat_y_load;
                        q_x        <= '0;
                        q_y        <= '0;
                        cnt        <= IW'(N - 1);
                        div_en     <= start_div;
                        busy       <= start_div;
                        state      <= start_div ? DIV : DONE;
                    end
                end

                DIV: begin
                    if (ge_x) rem_x <= rem_x - dsh;
                    if (ge_y) rem_y <= rem_y - dsh;
                    q_x <= {q_x[N-2:0], ge_x};
                    q_y <= {q_y[N-2:0], ge_y};
                    dsh <= dsh >> 1;
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - IW'(1);
                    end
                end

                DONE: begin
                    if (!div_en)
                        x_c <= '0;
                    else if (sat_x || q_x > Q_HMAX)
                        x_c <= '1;
                    else
                        x_c <= q_x[H_BITS-1:0];

                    if (!div_en)
                        y_c <= '0;
                    else if (sat_y || q_y > Q_VMAX)
                        y_c <= '1;
                    else
                        y_c <= q_y[V_BITS-1:0];

                    pix_count <= snap_count;
                    detected  <= div_en;
                    valid     <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_skin_centroid.sv
// tb_skin_centroid: drives mask frames into three skin_centroid instances
// (MIN_PIXELS = 4, 1, 64) and compares results with a frame-level model.
module tb_skin_centroid;

    localparam int H = 11;
    localparam int V = 11;
    localparam int N = 11;
    localparam int MINS [3] = '{4, 1, 64};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ce, de, hs, vs;
    logic [7:0] skin;

    logic [H-1:0]   xc_w    [3];
    logic [V-1:0]   yc_w    [3];
    logic [H+V-1:0] n_w     [3];
    logic           det_w   [3];
    logic           valid_w [3];
    logic           busy_w  [3];
    logic           ovr_w   [3];

    skin_centroid #(.H_BITS(H), .V_BITS(V), .MIN_PIXELS(4)) u_min4 (
        .clk(clk), .rst(rst), .ce(ce), .skin(skin), .de_in(de), .hsync_in(hs),
        .vsync_in(vs), .x_c(xc_w[0]), .y_c(yc_w[0]), .pix_count(n_w[0]),
        .detected(det_w[0]), .valid(valid_w[0]), .busy(busy_w[0]), .overrun(ovr_w[0]));

    skin_centroid #(.H_BITS(H), .V_BITS(V), .MIN_PIXELS(1)) u_min1 (
        .clk(clk), .rst(rst), .ce(ce), .skin(skin), .de_in(de), .hsync_in(hs),
        .vsync_in(vs), .x_c(xc_w[1]), .y_c(yc_w[1]), .pix_count(n_w[1]),
        .detected(det_w[1]), .valid(valid_w[1]), .busy(busy_w[1]), .overrun(ovr_w[1]));

    skin_centroid #(.H_BITS(H), .V_BITS(V), .MIN_PIXELS(64)) u_min64 (
        .clk(clk), .rst(rst), .ce(ce), .skin(skin), .de_in(de), .hsync_in(hs),
        .vsync_in(vs), .x_c(xc_w[2]), .y_c(yc_w[2]), .pix_count(n_w[2]),
        .detected(det_w[2]), .valid(valid_w[2]), .busy(busy_w[2]), .overrun(ovr_w[2]));

    int checks = 0;
    int passed = 0;

    bit mask [32][16];             // mask[x][y]: pixel (x,y) is skin
    int m_n, m_sx, m_sy;           // model: count, sum of x, sum of y

    int cap_lat [3], cap_vcnt [3], cap_x [3], cap_y [3], cap_n [3], cap_det [3], cap_busy0 [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mask();
        for (int xi = 0; xi < 32; xi++)
            for (int yi = 0; yi < 16; yi++)
                mask[xi][yi] = 1'b0;
    endtask

    // Frame-level reference: count and coordinate sums of the skin pixels.
    task automatic compute_model(input int w, input int h);
        m_n = 0; m_sx = 0; m_sy = 0;
        for (int yi = 0; yi < h; yi++)
            for (int xi = 0; xi < w; xi++)
                if (mask[xi][yi]) begin
                    m_n++;
                    m_sx += xi;
                    m_sy += yi;
                end
    endtask

    // Active lines followed by blanking; skin is driven nonzero during
    // blanking to show that only de=1 cycles count.
    task automatic send_frame(input int w, input int h);
        for (int yi = 0; yi < h; yi++) begin
            for (int xi = 0; xi < w; xi++) begin
                de = 1'b1; hs = 1'b0;
                skin = mask[xi][yi] ? 8'hFF : 8'h00;
                tick();
            end
            de = 1'b0; skin = 8'hFF; hs = 1'b1;
            tick();
            skin = 8'h00; hs = 1'b0;
            tick();
            tick();
        end
    endtask

    // Raise vsync, then watch every instance for valid within a bounded
    // window. Latency is counted in clock edges after the frame-end edge.
    task automatic wait_results(input int budget);
        for (int i = 0; i < 3; i++) begin
            cap_vcnt[i] = 0; cap_lat[i] = -1;
            cap_x[i] = -1; cap_y[i] = -1; cap_n[i] = -1; cap_det[i] = -1;
        end
        vs = 1'b1; de = 1'b0; skin = 8'h00;
        tick();
        for (int i = 0; i < 3; i++) cap_busy0[i] = busy_w[i];
        vs = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            for (int i = 0; i < 3; i++)
                if (valid_w[i]) begin
                    if (cap_vcnt[i] == 0) begin
                        cap_lat[i] = k;
                        cap_x[i] = xc_w[i]; cap_y[i] = yc_w[i];
                        cap_n[i] = n_w[i];  cap_det[i] = det_w[i];
                    end
                    cap_vcnt[i]++;
                end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0; skin = 8'h00;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({xc_w[i], yc_w[i], n_w[i], det_w[i], valid_w[i], busy_w[i], ovr_w[i]} !== '0)
                $display("FAIL reset[min%0d]: outputs x=%0d y=%0d n=%0d det=%0b v=%0b busy=%0b ovr=%0b, want all 0",
                         MINS[i], xc_w[i], yc_w[i], n_w[i], det_w[i], valid_w[i], busy_w[i], ovr_w[i]);
            else passed++;
        end
        rst = 1'b0;
        tick();
    endtask

    // One frame scenario; id 0..3 are directed, 4 is a random mask.
    task automatic test_frame_case(input int id);
        int    w, h, dens;
        int    ediv, ex, ey, elat;
        string name;
        clear_mask();
        case (id)
            0: begin
                name = "centroid"; w = 8; h = 4;
                for (int xi = 2; xi <= 5; xi++) begin mask[xi][1] = 1'b1; mask[xi][2] = 1'b1; end
            end
            1: begin name = "single_pixel"; w = 8; h = 4; mask[7][3] = 1'b1; end
            2: begin name = "empty"; w = 8; h = 4; end
            3: begin
                name = "below_threshold"; w = 12; h = 3;
                for (int xi = 0; xi < 10; xi++) mask[xi][2] = 1'b1;
            end
            default: begin
                name = "random"; w = 4 + $urandom_range(0, 16); h = 2 + $urandom_range(0, 6);
                dens = $urandom_range(1, 3);
                for (int yi = 0; yi < h; yi++)
                    for (int xi = 0; xi < w; xi++)
                        mask[xi][yi] = ($urandom_range(0, 3) < dens);
            end
        endcase
        compute_model(w, h);
        send_frame(w, h);
        wait_results(30);
        for (int i = 0; i < 3; i++) begin
            ediv = (m_n >= MINS[i]) && (m_n != 0);
            ex   = ediv ? m_sx / m_n : 0;
            ey   = ediv ? m_sy / m_n : 0;
            // N+2 cycles from the frame-end cycle = N+1 edges after its edge.
            elat = ediv ? N + 1 : 1;
            checks++;
            if (cap_lat[i] !== elat)
                $display("FAIL %s[min%0d] latency: got %0d, want %0d", name, MINS[i], cap_lat[i], elat);
            else passed++;
            checks++;
            if (cap_vcnt[i] !== 1)
                $display("FAIL %s[min%0d] valid_cycles: got %0d, want 1", name, MINS[i], cap_vcnt[i]);
            else passed++;
            checks++;
            if (cap_x[i] !== ex || cap_y[i] !== ey)
                $display("FAIL %s[min%0d] centroid: got (%0d,%0d), want (%0d,%0d)", name, MINS[i], cap_x[i], cap_y[i], ex, ey);
            else passed++;
            checks++;
            if (cap_n[i] !== m_n || cap_det[i] !== ediv)
                $display("FAIL %s[min%0d] count/detected: got %0d/%0d, want %0d/%0d", name, MINS[i], cap_n[i], cap_det[i], m_n, ediv);
            else passed++;
            checks++;
            if (cap_busy0[i] !== ediv)
                $display("FAIL %s[min%0d] busy: got %0d, want %0d", name, MINS[i], cap_busy0[i], ediv);
            else passed++;
        end
    endtask

    task automatic test_overrun();
        int a_n, a_sx, a_sy, lat, vc, gx, gy, gn;
        clear_mask();
        for (int xi = 1; xi <= 6; xi++) mask[xi][1] = 1'b1;
        mask[3][2] = 1'b1;
        compute_model(8, 3);
        a_n = m_n; a_sx = m_sx; a_sy = m_sy;
        send_frame(8, 3);
        vs = 1'b1; tick();                         // frame A ends (edge 0)
        vs = 1'b0; de = 1'b1; skin = 8'hFF;        // two pixels of frame B
        tick(); tick();
        de = 1'b0; skin = 8'h00; vs = 1'b1;        // frame B ends mid-division
        tick();
        checks++;
        if (ovr_w[0] !== 1'b1) $display("FAIL overrun pulse: got %0b, want 1", ovr_w[0]);
        else passed++;
        vs = 1'b0;
        tick();
        checks++;
        if (ovr_w[0] !== 1'b0) $display("FAIL overrun width: got %0b one cycle later, want 0", ovr_w[0]);
        else passed++;
        lat = -1; vc = 0; gx = -1; gy = -1; gn = -1;
        for (int k = 5; k <= 30; k++) begin
            tick();
            if (valid_w[0]) begin
                if (vc == 0) begin lat = k; gx = xc_w[0]; gy = yc_w[0]; gn = n_w[0]; end
                vc++;
            end
        end
        checks++;
        if (lat !== N + 1 || vc !== 1)
            $display("FAIL overrun first_valid: got latency %0d count %0d, want %0d and 1", lat, vc, N + 1);
        else passed++;
        checks++;
        if (gx !== a_sx / a_n || gy !== a_sy / a_n || gn !== a_n)
            $display("FAIL overrun first_result: got (%0d,%0d) n=%0d, want (%0d,%0d) n=%0d",
                     gx, gy, gn, a_sx / a_n, a_sy / a_n, a_n);
        else passed++;
        clear_mask();
        mask[0][0] = 1'b1; mask[5][0] = 1'b1; mask[2][1] = 1'b1; mask[4][2] = 1'b1; mask[5][2] = 1'b1;
        compute_model(6, 3);
        send_frame(6, 3);
        wait_results(30);
        checks++;
        if (cap_x[0] !== m_sx / m_n || cap_y[0] !== m_sy / m_n || cap_n[0] !== m_n)
            $display("FAIL overrun third_frame: got (%0d,%0d) n=%0d, want (%0d,%0d) n=%0d",
                     cap_x[0], cap_y[0], cap_n[0], m_sx / m_n, m_sy / m_n, m_n);
        else passed++;
    endtask

    task automatic test_ce_stall();
        int lat [2], vc [2], gx [2], gy [2], gn [2];
        int stall_valid, stall_busy;
        clear_mask();
        for (int xi = 3; xi <= 9; xi++) mask[xi][0] = 1'b1;
        mask[1][3] = 1'b1; mask[8][3] = 1'b1; mask[9][2] = 1'b1;
        compute_model(10, 4);
        send_frame(10, 4);
        vs = 1'b1; tick();
        vs = 1'b0;
        tick(); tick(); tick();
        ce = 1'b0;
        stall_valid = 0; stall_busy = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (valid_w[0] || valid_w[1]) stall_valid++;
            if (!busy_w[0] || !busy_w[1]) stall_busy = 0;
        end
        ce = 1'b1;
        checks++;
        if (stall_valid !== 0 || stall_busy !== 1)
            $display("FAIL ce_stall hold: got %0d valids, busy held %0d, want 0 and 1", stall_valid, stall_busy);
        else passed++;
        for (int i = 0; i < 2; i++) begin lat[i] = -1; vc[i] = 0; gx[i] = -1; gy[i] = -1; gn[i] = -1; end
        for (int k = 14; k <= 40; k++) begin
            tick();
            for (int i = 0; i < 2; i++)
                if (valid_w[i]) begin
                    if (vc[i] == 0) begin lat[i] = k; gx[i] = xc_w[i]; gy[i] = yc_w[i]; gn[i] = n_w[i]; end
                    vc[i]++;
                end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (lat[i] !== N + 1 + 10 || vc[i] !== 1)
                $display("FAIL ce_stall[min%0d] latency: got %0d count %0d, want %0d and 1", MINS[i], lat[i], vc[i], N + 11);
            else passed++;
            checks++;
            if (gx[i] !== m_sx / m_n || gy[i] !== m_sy / m_n || gn[i] !== m_n)
                $display("FAIL ce_stall[min%0d] result: got (%0d,%0d) n=%0d, want (%0d,%0d) n=%0d",
                         MINS[i], gx[i], gy[i], gn[i], m_sx / m_n, m_sy / m_n, m_n);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_div();
        int vc;
        clear_mask();
        for (int xi = 0; xi < 8; xi++) mask[xi][1] = 1'b1;
        send_frame(8, 3);
        vs = 1'b1; tick();
        vs = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({xc_w[i], yc_w[i], n_w[i], det_w[i], valid_w[i], busy_w[i], ovr_w[i]} !== '0)
                $display("FAIL reset_mid_div[min%0d]: outputs x=%0d y=%0d n=%0d busy=%0b, want all 0",
                         MINS[i], xc_w[i], yc_w[i], n_w[i], busy_w[i]);
            else passed++;
        end
        tick();
        rst = 1'b0;
        vc = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (valid_w[0] || valid_w[1]) vc++;
        end
        checks++;
        if (vc !== 0) $display("FAIL reset_mid_div no_valid: got %0d valid cycles, want 0", vc);
        else passed++;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        for (int id = 0; id < 4; id++) test_frame_case(id);
        repeat (6) test_frame_case(4);
        test_overrun();
        test_ce_stall();
        test_reset_mid_div();
        test_frame_case(0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/skin_centroid.md
Name: skin_centroid

Overview:
- Sits directly downstream of the skin binarization stage; consumes its binary mask stream (skin, de, hsync, vsync).
- Tracks pixel coordinates from the sync/enable timing, and accumulates the count and the coordinate sums of skin pixels over each frame.
- At frame end, computes the floor-division centroid with an iterative restoring divider and presents it with a one-cycle valid strobe.
- Feeds the hand-position tracking and overlay logic.

Parameters:
- H_BITS, 11, width of the x coordinate (lines up to 2048 px).
- V_BITS, 11, width of the y coordinate.
- MIN_PIXELS, 64, minimum skin pixel count for a detection to be declared.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- ce  in  1  clock enable; all state advances only when ce=1.
- skin  in  8  binary mask pixel (0x00 or 0xFF); a pixel is skin when nonzero.
- de_in  in  1  data enable, active-high.
- hsync_in  in  1  horizontal sync, active-high (unused for counting; kept for timing alignment).
- vsync_in  in  1  vertical sync, active-high; its rising edge marks frame end.
- x_c  out  H_BITS  centroid x.
- y_c  out  V_BITS  centroid y.
- pix_count  out  H_BITS+V_BITS  skin pixel count of the last completed frame.
- detected  out  1  1 when the last frame's pix_count >= MIN_PIXELS.
- valid  out  1  one-cycle strobe: result registers were just updated.
- busy  out  1  high while the divider runs.
- overrun  out  1  one-cycle strobe: a frame end was dropped because the divider was busy.

Behaviour:
- Reset values: all outputs 0. Counters, accumulators and edge-detect registers are 0. FSM is in IDLE.
- Edge detection: registers de_d and vs_d are updated on ce. Frame end is vsync_in=1 while vs_d=0. Line end is de_in=0 while de_d=1.
- x counter:
  - Increments per de_in=1 cycle and saturates at 2^H_BITS-1.
  - Cleared at line end.
- y counter:
  - Increments at line end and saturates at 2^V_BITS-1.
  - Cleared at frame end.
- Accumulators (count, sum_x, sum_y):
  - When de_in=1 and skin!=0: count+=1, sum_x+=x, sum_y+=y, using the x/y values before their increment in that cycle.
  - Widths: count H_BITS+V_BITS; sum_x 2*H_BITS+V_BITS; sum_y H_BITS+2*V_BITS. No overflow is possible.
- Frame end handling:
  - The accumulators are copied to snapshot registers and cleared in the same cycle, so the next frame accumulates while the divider runs.
  - A pixel present in the frame-end cycle belongs to the new frame.
- FSM:
  - IDLE: on frame end, load the snapshot.
    - If snap_count >= MIN_PIXELS and snap_count != 0, go to DIV.
    - Otherwise go to DONE with detected=0 and quotients forced to 0.
  - DIV:
    - Two restoring dividers run in parallel (sum_x/count, sum_y/count), one quotient bit per ce cycle, MSB first.
    - N = max(H_BITS,V_BITS) iterations, then go to DONE. busy=1 throughout DIV.
  - DONE: register x_c, y_c, pix_count and detected; assert valid for one cycle; return to IDLE.
- Latency: valid asserts N+2 ce-cycles after the frame-end cycle when dividing, and 2 ce-cycles after it when the division is skipped.
- Quotient rules: floor division. A quotient above the coordinate width saturates (cannot occur for a consistent count).
- Frame end during DIV or DONE:
  - The accumulators are cleared (that frame is lost) and the snapshot is not overwritten.
  - overrun pulses for one cycle; the current division completes unaffected.
- ce=0: every register holds, including the FSM and the divider. valid and overrun are held low in the cycle where ce=0.
- Reset mid-operation:
  - The FSM returns to IDLE immediately and outputs clear to 0.
  - valid does not assert for the interrupted frame.

Test Plan:
- Centroid (MIN_PIXELS=4): 8x4 frame with skin=0xFF at x=2..5 on lines y=1,2, then a vsync rise. Required: pix_count=8, x_c=3 (28/8), y_c=1 (12/8), detected=1, valid one cycle, 13 cycles after frame end.
- Single pixel (MIN_PIXELS=1): only (7,3) is skin. Required: x_c=7, y_c=3, pix_count=1, detected=1.
- Empty frame: all skin=0, then frame end. Required: valid 2 cycles later; x_c=0, y_c=0, pix_count=0, detected=0; no division by zero.
- Below threshold (MIN_PIXELS=64): 10 skin pixels. Required: detected=0, pix_count=10, x_c=y_c=0.
- Overrun: a second vsync rise 3 cycles into DIV. Required: overrun=1 for one cycle; the first result is still correct. The third frame's result reflects only that frame's pixels.
- Reset/ce: assert rst 5 cycles into DIV → all outputs 0, no valid. Separately, hold ce=0 for 10 cycles mid-DIV → valid is delayed by exactly 10 cycles with an unchanged result.
